// File: rtl/fifo_pkg.sv
// Shared definitions for the FIFO-side transmit blocks.
package fifo_pkg;

   // Transmit arbiter FSM states.
   typedef enum logic [1:0] {
      StIdle   = 2'd0,
      StStrobe = 2'd1,
      StWait   = 2'd2,
      StFinish = 2'd3
   } tx_state_e;

   // Default timing towards the FT2232H FIFO interface.
   localparam int unsigned DefGapCycles = 6;
   localparam int unsigned DefStrobeLen = 2;
   localparam int unsigned DefMaxRetry  = 3;

   // Width of the saturating dropped-byte counter.
   localparam int unsigned DropCntW = 16;

endpackage

// File: rtl/rr_pick2.sv
// Two-way round-robin pick: a sole valid requester wins, and on a tie the
// requester that was not served last wins.
module rr_pick2
   import fifo_pkg::*;
(
   input  logic [1:0] valid_i,
   input  logic       last_i,
   output logic [1:0] grant_o
);

   // One-hot grant from the valids and the last-served pointer.
   always_comb begin
      grant_o = 2'b00;
      unique case (valid_i)
         2'b01:   grant_o = 2'b01;
         2'b10:   grant_o = 2'b10;
         2'b11:   grant_o = last_i ? 2'b01 : 2'b10;
         default: grant_o = 2'b00;
      endcase
   end

endmodule

// File: rtl/fifo_tx_arbiter.sv
// Arbitrates two byte requesters onto the FT2232H FIFO transmit interface.
// Each accepted byte is strobed for STROBE_LEN cycles, followed by a
// GAP_CYCLES quiet gap (GAP_CYCLES must be at least 5); a downstream error
// seen during an attempt triggers up to MAX_RETRY re-strobes of the same byte
// before it is dropped.
module fifo_tx_arbiter
   import fifo_pkg::*;
#(
   parameter int unsigned GAP_CYCLES = DefGapCycles,
   parameter int unsigned MAX_RETRY  = DefMaxRetry,
   parameter int unsigned STROBE_LEN = DefStrobeLen
) (
   input  logic                clk_i,
   input  logic                reset_i,
   input  logic                req0_valid_i,
   input  logic [7:0]          req0_data_i,
   output logic                req0_ready_o,
   input  logic                req1_valid_i,
   input  logic [7:0]          req1_data_i,
   output logic                req1_ready_o,
   output logic [7:0]          tx_data_o,
   output logic                tx_data_rdy_o,
   input  logic                tx_err_i,
   output logic                sent_o,
   output logic                drop_o,
   output logic [DropCntW-1:0] drop_cnt_o,
   output logic                busy_o
);

   tx_state_e           state_q;
   logic [7:0]          tx_data_q;
   logic                tx_rdy_q;
   logic                sent_q;
   logic                drop_q;
   logic [DropCntW-1:0] drop_cnt_q;
   logic [7:0]          cnt_q;
   logic [7:0]          retry_q;
   logic                err_q;
   logic                last_q;

   logic [1:0]          grant;
   logic                idle;
   logic                accept;
   logic [7:0]          sel_data;
   logic                err_now;

   assign idle = (state_q == StIdle);

   rr_pick2 u_rr_pick2 (
      .valid_i ({req1_valid_i, req0_valid_i}),
      .last_i  (last_q),
      .grant_o (grant)
   );

   // Ready is only offered in IDLE, and only to the picked requester.
   assign req0_ready_o = idle & grant[0];
   assign req1_ready_o = idle & grant[1];
   assign accept       = idle & (grant != 2'b00);
   assign sel_data     = grant[1] ? req1_data_i : req0_data_i;

   // An error in the last WAIT cycle still belongs to the current attempt.
   assign err_now = err_q | tx_err_i;

   assign tx_data_o     = tx_data_q;
   assign tx_data_rdy_o = tx_rdy_q;
   assign sent_o        = sent_q;
   assign drop_o        = drop_q;
   assign drop_cnt_o    = drop_cnt_q;
   assign busy_o        = ~idle;

   // Transmit FSM with registered strobe, data and status outputs.
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         state_q    <= StIdle;
         tx_data_q  <= 8'h00;
         tx_rdy_q   <= 1'b0;
         sent_q     <= 1'b0;
         drop_q     <= 1'b0;
         drop_cnt_q <= '0;
         cnt_q      <= 8'd0;
         retry_q    <= 8'd0;
         err_q      <= 1'b0;
         last_q     <= 1'b1;
      end else begin
         sent_q <= 1'b0;
         drop_q <= 1'b0;
         case (state_q)
            StIdle: begin
               if (accept) begin
                  tx_data_q <= sel_data;
                  last_q    <= grant[1];
                  retry_q   <= 8'd0;
                  err_q     <= 1'b0;
                  cnt_q     <= 8'd0;
                  tx_rdy_q  <= 1'b1;
                  state_q   <= StStrobe;
               end
            end
            StStrobe: begin
               if (tx_err_i) begin
                  err_q <= 1'b1;
               end
               if (cnt_q == 8'(STROBE_LEN - 1)) begin
                  cnt_q    <= 8'd0;
                  tx_rdy_q <= 1'b0;
                  state_q  <= StWait;
               end else begin
                  cnt_q <= cnt_q + 8'd1;
               end
            end
            StWait: begin
               if (cnt_q == 8'(GAP_CYCLES - 1)) begin
                  cnt_q <= 8'd0;
                  if (!err_now) begin
                     sent_q  <= 1'b1;
                     state_q <= StFinish;
                  end else if (retry_q < 8'(MAX_RETRY)) begin
                     retry_q  <= retry_q + 8'd1;
                     err_q    <= 1'b0;
                     tx_rdy_q <= 1'b1;
                     state_q  <= StStrobe;
                  end else begin
                     drop_q <= 1'b1;
                     if (drop_cnt_q != '1) begin
                        drop_cnt_q <= drop_cnt_q + 1'b1;
                     end
                     state_q <= StFinish;
                  end
               end else begin
                  cnt_q <= cnt_q + 8'd1;
                  if (tx_err_i) begin
                     err_q <= 1'b1;
                  end
               end
            end
            StFinish: begin
               state_q <= StIdle;
            end
            default: begin
               // Recover to reset values; the drop count is deliberately kept.
               state_q   <= StIdle;
               tx_data_q <= 8'h00;
               tx_rdy_q  <= 1'b0;
               sent_q    <= 1'b0;
               drop_q    <= 1'b0;
               cnt_q     <= 8'd0;
               retry_q   <= 8'd0;
               err_q     <= 1'b0;
               last_q    <= 1'b1;
            end
         endcase
      end
   end

endmodule
